// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out converter.
// Takes a DATA_WIDTH word over a valid/ready handshake and emits it as
// DATA_WIDTH/LANES beats of LANES bits. MSB_FIRST selects which end of the
// word leaves first. A word can be accepted on the last-beat transfer of the
// previous word, so streaming words produce no idle cycle between them.
module piso_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [LANES-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last
);

  localparam int BEATS = DATA_WIDTH / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] shreg_adv;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LANES-1:0]      lane;
  logic                  accept;
  logic                  xfer;

  // Pick the lane at the output end and the register advanced by one beat
  // (zero-filled from the far end) according to the bit order.
  always_comb begin
    if (MSB_FIRST != 0) begin
      lane      = shreg_q[DATA_WIDTH-1 -: LANES];
      shreg_adv = shreg_q << LANES;
    end else begin
      lane      = shreg_q[LANES-1:0];
      shreg_adv = shreg_q >> LANES;
    end
  end

  // Handshake decode: din_ready also opens on the last-beat transfer so the
  // next word loads without a bubble; dout is gated to zero when not valid.
  always_comb begin
    dout_valid = (state_q == SHIFT);
    dout_last  = dout_valid & (cnt_q == LAST_CNT);
    xfer       = dout_valid & dout_ready;
    din_ready  = (state_q == IDLE) | (xfer & dout_last);
    accept     = din_valid & din_ready;
    dout       = dout_valid ? lane : '0;
  end

  // Next-state logic for the FSM, shift register and beat counter.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = din;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (dout_last) begin
            if (accept) begin
              shreg_d = din;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
              shreg_d = '0;
              cnt_d   = '0;
            end
          end else begin
            shreg_d = shreg_adv;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any word in flight immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: directed scenarios plus a randomized run
// against a queue-based model of the beats each accepted word must produce.
module tb_piso_serializer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  // 16-bit, 1 lane, LSB first
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        dout_ready = 1'b0;
  logic        din_ready;
  logic [0:0]  dout;
  logic        dout_valid;
  logic        dout_last;

  // 16-bit, 4 lanes: one MSB first (m4), one LSB first (l4), shared inputs
  logic [15:0] din4 = '0;
  logic        din4_valid = 1'b0;
  logic        dout4_ready = 1'b0;
  logic        m4_ready, m4_valid, m4_last;
  logic [3:0]  m4_dout;
  logic        l4_ready, l4_valid, l4_last;
  logic [3:0]  l4_dout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_WIDTH(16), .LANES(1), .MSB_FIRST(0)) u_dut (
    .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last)
  );

  piso_serializer #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(1)) u_m4 (
    .clk(clk), .resetn(resetn), .din(din4), .din_valid(din4_valid),
    .din_ready(m4_ready), .dout(m4_dout), .dout_valid(m4_valid),
    .dout_ready(dout4_ready), .dout_last(m4_last)
  );

  piso_serializer #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(0)) u_l4 (
    .clk(clk), .resetn(resetn), .din(din4), .din_valid(din4_valid),
    .din_ready(l4_ready), .dout(l4_dout), .dout_valid(l4_valid),
    .dout_ready(dout4_ready), .dout_last(l4_last)
  );

  // Beat k of word w: lane index counted from the end that leaves first.
  function automatic logic [15:0] beat_of(input logic [15:0] w, input int k,
                                          input int lanes, input bit msb);
    int beats;
    int idx;
    logic [15:0] mask;
    beats = 16 / lanes;
    idx   = msb ? (beats - 1 - k) : k;
    mask  = (16'h1 << lanes) - 16'h1;
    return (w >> (idx * lanes)) & mask;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [11:0] got;
    resetn = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    din4_valid = 1'b0;
    dout4_ready = 1'b0;
    #2;
    got = {dout_valid, dout_last, dout, m4_valid, m4_last, m4_dout, l4_valid, l4_last, l4_dout[0]};
    n_cmp++;
    if (got !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got %0h expected 0", got);
    end
    step;
    step;
    resetn = 1'b1;
    #1;
    n_cmp++;
    if ({din_ready, m4_ready, l4_ready} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_din_ready: got %b expected 111", {din_ready, m4_ready, l4_ready});
    end
  endtask

  task automatic test_lsb_first;
    int exp_bits[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    logic [2:0] exp_v;
    din = 16'hA5C3;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    #1;
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL lsb_accept_ready: got %b expected 1", din_ready);
    end
    step;
    din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      exp_v = {1'b1, (i == 15), exp_bits[i][0]};
      n_cmp++;
      if ({dout_valid, dout_last, dout} !== exp_v) begin
        n_err++;
        $display("FAIL lsb_beat%0d: got %b expected %b", i, {dout_valid, dout_last, dout}, exp_v);
      end
      step;
    end
    #1;
    n_cmp++;
    if ({dout_valid, dout_last, dout, din_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL lsb_after_idle: got %b expected 0001", {dout_valid, dout_last, dout, din_ready});
    end
  endtask

  task automatic test_lanes4;
    logic [3:0] ex_m[4] = '{4'hA, 4'h5, 4'hC, 4'h3};
    logic [3:0] ex_l[4] = '{4'h3, 4'hC, 4'h5, 4'hA};
    din4 = 16'hA5C3;
    din4_valid = 1'b1;
    dout4_ready = 1'b1;
    step;
    din4_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({m4_valid, m4_last, m4_dout} !== {1'b1, (i == 3), ex_m[i]}) begin
        n_err++;
        $display("FAIL msb4_beat%0d: got %h expected %h", i, {m4_valid, m4_last, m4_dout}, {1'b1, (i == 3), ex_m[i]});
      end
      n_cmp++;
      if ({l4_valid, l4_last, l4_dout} !== {1'b1, (i == 3), ex_l[i]}) begin
        n_err++;
        $display("FAIL lsb4_beat%0d: got %h expected %h", i, {l4_valid, l4_last, l4_dout}, {1'b1, (i == 3), ex_l[i]});
      end
      step;
    end
    #1;
    n_cmp++;
    if ({m4_valid, m4_dout, l4_valid, l4_dout} !== 10'h0) begin
      n_err++;
      $display("FAIL lanes4_idle: got %h expected 0", {m4_valid, m4_dout, l4_valid, l4_dout});
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_v;
    din = 16'h0001;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    #1;
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready_c0: got %b expected 1", din_ready);
    end
    step;
    din = 16'h8000;
    for (int c = 1; c <= 32; c++) begin
      #1;
      exp_v = {1'b1, (c == 16 || c == 32), (c == 1 || c == 32), (c == 16 || c == 32)};
      n_cmp++;
      if ({dout_valid, dout_last, dout, din_ready} !== exp_v) begin
        n_err++;
        $display("FAIL b2b_cycle%0d: got %b expected %b", c, {dout_valid, dout_last, dout, din_ready}, exp_v);
      end
      step;
      if (c == 16) din_valid = 1'b0;
    end
    #1;
    n_cmp++;
    if ({dout_valid, dout} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_idle: got %b expected 00", {dout_valid, dout});
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] w;
    int beat;
    logic [2:0] exp_v;
    w = 16'($urandom);
    din = w;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    step;
    din_valid = 1'b0;
    beat = 0;
    for (int c = 0; c < 19; c++) begin
      dout_ready = (c < 5 || c > 7);
      #1;
      exp_v = {1'b1, (beat == 15), w[beat]};
      n_cmp++;
      if ({dout_valid, dout_last, dout} !== exp_v) begin
        n_err++;
        $display("FAIL bp_cycle%0d: got %b expected %b", c, {dout_valid, dout_last, dout}, exp_v);
      end
      if (dout_ready) beat++;
      step;
    end
    dout_ready = 1'b1;
    #1;
    n_cmp++;
    if (dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done: got %b expected 0", dout_valid);
    end
  endtask

  task automatic test_busy;
    logic [15:0] w;
    logic [3:0] exp_v;
    w = 16'($urandom) & 16'h7FFE;
    din = w;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    step;
    din_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      din_valid = (c >= 2 && c <= 10);
      din = din_valid ? 16'hFFFF : 16'h0000;
      #1;
      exp_v = {1'b1, (c == 15), w[c], (c == 15)};
      n_cmp++;
      if ({dout_valid, dout_last, dout, din_ready} !== exp_v) begin
        n_err++;
        $display("FAIL busy_cycle%0d: got %b expected %b", c, {dout_valid, dout_last, dout, din_ready}, exp_v);
      end
      step;
    end
    din_valid = 1'b0;
    #1;
    n_cmp++;
    if (dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL busy_not_accepted: got %b expected 0", dout_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] w;
    w = 16'hFF80;
    din = w;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    step;
    din_valid = 1'b0;
    for (int c = 0; c < 7; c++) step;
    #1;
    n_cmp++;
    if ({dout_valid, dout_last, dout} !== 3'b101) begin
      n_err++;
      $display("FAIL rst_mid_pre: got %b expected 101", {dout_valid, dout_last, dout});
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({dout_valid, dout_last, dout} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_mid_async: got %b expected 000", {dout_valid, dout_last, dout});
    end
    #1;
    resetn = 1'b1;
    #1;
    n_cmp++;
    if ({din_ready, dout_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_mid_release: got %b expected 10", {din_ready, dout_valid});
    end
    step;
    step;
    n_cmp++;
    if (dout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_no_resume: got %b expected 0", dout_valid);
    end
    w = 16'h00FF;
    din = w;
    din_valid = 1'b1;
    step;
    din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_cmp++;
      if ({dout_valid, dout_last, dout} !== {1'b1, (i == 15), w[i]}) begin
        n_err++;
        $display("FAIL rst_mid_new_beat%0d: got %b expected %b", i, {dout_valid, dout_last, dout}, {1'b1, (i == 15), w[i]});
      end
      step;
    end
  endtask

  task automatic test_random;
    logic [15:0] q1[$];
    logic [15:0] q4[$];
    bit ev, el, er;
    logic [15:0] ed;
    int errs_before;
    errs_before = n_err;
    for (int cyc = 0; cyc < 800; cyc++) begin
      din = 16'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      din4 = 16'($urandom);
      din4_valid = ($urandom_range(0, 2) != 0);
      dout4_ready = ($urandom_range(0, 2) != 0);
      #1;
      ev = (q1.size() != 0);
      el = (q1.size() == 1);
      ed = ev ? q1[0] : 16'h0;
      er = !ev || (el && dout_ready);
      n_cmp++;
      if ({dout_valid, dout_last, dout, din_ready} !== {ev, el, ed[0], er}) begin
        n_err++;
        if (n_err - errs_before < 10)
          $display("FAIL rand1_cycle%0d: got %b expected %b", cyc, {dout_valid, dout_last, dout, din_ready}, {ev, el, ed[0], er});
      end
      if (ev && dout_ready) void'(q1.pop_front());
      if (din_valid && er) for (int k = 0; k < 16; k++) q1.push_back(beat_of(din, k, 1, 1'b0));
      ev = (q4.size() != 0);
      el = (q4.size() == 1);
      ed = ev ? q4[0] : 16'h0;
      er = !ev || (el && dout4_ready);
      n_cmp++;
      if ({m4_valid, m4_last, m4_dout, m4_ready} !== {ev, el, ed[3:0], er}) begin
        n_err++;
        if (n_err - errs_before < 10)
          $display("FAIL rand4_cycle%0d: got %b expected %b", cyc, {m4_valid, m4_last, m4_dout, m4_ready}, {ev, el, ed[3:0], er});
      end
      if (ev && dout4_ready) void'(q4.pop_front());
      if (din4_valid && er) for (int k = 0; k < 4; k++) q4.push_back(beat_of(din4, k, 4, 1'b1));
      step;
    end
    din_valid = 1'b0;
    din4_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_lsb_first;
    test_lanes4;
    test_back_to_back;
    test_backpressure;
    test_busy;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
